// File: rtl/prism_load_seq_if.sv
// Host-side command/word stream and PRISM debug write port of the load sequencer.
// The sequencer itself uses the slave modport; the host side uses master.
interface prism_load_seq_if;
  logic        cmd_start;
  logic [5:0]  cmd_base;
  logic [3:0]  cmd_count;
  logic        cmd_autorun;
  logic        cmd_abort;
  logic        irq_clr;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;
  logic        prism_reset;
  logic        prism_enable;
  logic [5:0]  prism_addr;
  logic        prism_wr;
  logic [31:0] prism_wdata;
  logic        busy;
  logic        done;
  logic        error;
  logic        irq;

  modport master (
    output cmd_start, cmd_base, cmd_count, cmd_autorun, cmd_abort, irq_clr,
    output word_valid, word_data,
    input  word_ready, prism_reset, prism_enable, prism_addr, prism_wr, prism_wdata,
    input  busy, done, error, irq
  );

  modport slave (
    input  cmd_start, cmd_base, cmd_count, cmd_autorun, cmd_abort, irq_clr,
    input  word_valid, word_data,
    output word_ready, prism_reset, prism_enable, prism_addr, prism_wr, prism_wdata,
    output busy, done, error, irq
  );
endinterface

// File: rtl/prism_load_seq.sv
// PRISM configuration sequencer: quiesces PRISM, streams buffered config words into consecutive
// debug addresses, then releases reset and optionally enables the FSM.
module prism_load_seq #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned TIMEOUT       = 255
) (
  input logic              clk,
  input logic              rst,
  prism_load_seq_if.slave  bus_io
);
  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  typedef enum logic [1:0] {StIdle, StQuiesce, StLoad, StRelease} state_e;

  state_e            state_q, state_d;
  logic [31:0]       mem_q [FIFO_DEPTH];
  logic [PtrW-1:0]   rptr_q, rptr_d, wptr_q, wptr_d;
  logic [CntW-1:0]   occ_q, occ_d;
  logic [4:0]        rem_q, rem_d;
  logic [3:0]        widx_q, widx_d;
  logic              autorun_q, autorun_d;
  logic [SetW-1:0]   settle_q, settle_d;
  logic [7:0]        idle_q, idle_d;
  logic              prism_reset_q, prism_reset_d;
  logic              prism_enable_q, prism_enable_d;
  logic [5:0]        prism_addr_q, prism_addr_d;
  logic              prism_wr_q, prism_wr_d;
  logic [31:0]       prism_wdata_q, prism_wdata_d;
  logic              error_q, error_d;
  logic              irq_q, irq_d;

  logic fifo_empty, fifo_full, word_ready, push, pop, flush, irq_set, abort, settle_done;
  logic unused_base;

  assign unused_base = ^bus_io.cmd_base[1:0];
  assign fifo_empty  = (occ_q == '0);
  assign fifo_full   = (occ_q == CntW'(FIFO_DEPTH));
  assign settle_done = (settle_q == SetW'(SETTLE_CYCLES - 1));
  assign abort       = bus_io.cmd_abort && (state_q != StIdle);

  // Stop accepting once the buffered words already cover every remaining write.
  assign word_ready = ((state_q == StQuiesce) || (state_q == StLoad)) && !fifo_full &&
                      (32'(occ_q) < 32'(rem_q));
  assign push       = bus_io.word_valid && word_ready;

  always_comb begin
    state_d        = state_q;
    rptr_d         = rptr_q;
    wptr_d         = wptr_q;
    occ_d          = occ_q;
    rem_d          = rem_q;
    widx_d         = widx_q;
    autorun_d      = autorun_q;
    settle_d       = settle_q;
    idle_d         = idle_q;
    prism_reset_d  = prism_reset_q;
    prism_enable_d = prism_enable_q;
    prism_addr_d   = prism_addr_q;
    prism_wr_d     = 1'b0;
    prism_wdata_d  = prism_wdata_q;
    error_d        = error_q;
    irq_set        = 1'b0;
    pop            = 1'b0;
    flush          = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.cmd_start) begin
          widx_d         = bus_io.cmd_base[5:2];
          rem_d          = (bus_io.cmd_count == 4'd0) ? 5'd16 : {1'b0, bus_io.cmd_count};
          autorun_d      = bus_io.cmd_autorun;
          flush          = 1'b1;
          error_d        = 1'b0;
          prism_enable_d = 1'b0;
          prism_reset_d  = 1'b1;
          settle_d       = '0;
          idle_d         = '0;
          state_d        = StQuiesce;
        end
      end
      StQuiesce: begin
        // The first pop is issued on the last settle cycle so its registered strobe lands
        // in the first LOAD cycle.
        if (settle_done) begin
          state_d = StLoad;
          pop     = !fifo_empty;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StLoad: begin
        if (rem_q == 5'd0) begin
          state_d        = StRelease;
          prism_reset_d  = 1'b0;
          prism_enable_d = autorun_q;
        end else if (!fifo_empty) begin
          pop = 1'b1;
        end else if (idle_q == 8'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          irq_set = 1'b1;
          flush   = 1'b1;
          state_d = StIdle;
        end else begin
          idle_d = idle_q + 8'd1;
        end
      end
      StRelease: begin
        irq_set = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (abort) begin
      pop            = 1'b0;
      flush          = 1'b1;
      prism_reset_d  = 1'b1;
      prism_enable_d = 1'b0;
      error_d        = 1'b1;
      irq_set        = 1'b1;
      state_d        = StIdle;
    end

    if (pop) begin
      prism_wr_d    = 1'b1;
      prism_addr_d  = {widx_q, 2'b00};
      prism_wdata_d = mem_q[rptr_q];
      widx_d        = widx_q + 4'd1;
      rem_d         = rem_q - 5'd1;
      idle_d        = '0;
    end

    if (flush) begin
      rptr_d = '0;
      wptr_d = '0;
      occ_d  = '0;
    end else begin
      rptr_d = rptr_q + PtrW'(pop);
      wptr_d = wptr_q + PtrW'(push);
      occ_d  = occ_q + CntW'(push) - CntW'(pop);
    end

    irq_d = (irq_q && !bus_io.irq_clr) || irq_set;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      rptr_q         <= '0;
      wptr_q         <= '0;
      occ_q          <= '0;
      rem_q          <= '0;
      widx_q         <= '0;
      autorun_q      <= 1'b0;
      settle_q       <= '0;
      idle_q         <= '0;
      prism_reset_q  <= 1'b0;
      prism_enable_q <= 1'b0;
      prism_addr_q   <= '0;
      prism_wr_q     <= 1'b0;
      prism_wdata_q  <= '0;
      error_q        <= 1'b0;
      irq_q          <= 1'b0;
    end else begin
      state_q        <= state_d;
      rptr_q         <= rptr_d;
      wptr_q         <= wptr_d;
      occ_q          <= occ_d;
      rem_q          <= rem_d;
      widx_q         <= widx_d;
      autorun_q      <= autorun_d;
      settle_q       <= settle_d;
      idle_q         <= idle_d;
      prism_reset_q  <= prism_reset_d;
      prism_enable_q <= prism_enable_d;
      prism_addr_q   <= prism_addr_d;
      prism_wr_q     <= prism_wr_d;
      prism_wdata_q  <= prism_wdata_d;
      error_q        <= error_d;
      irq_q          <= irq_d;
    end
  end

  // Storage needs no reset; occupancy tracking decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wptr_q] <= bus_io.word_data;
    end
  end

  assign bus_io.word_ready   = word_ready;
  assign bus_io.prism_reset  = prism_reset_q;
  assign bus_io.prism_enable = prism_enable_q;
  assign bus_io.prism_addr   = prism_addr_q;
  assign bus_io.prism_wr     = prism_wr_q;
  assign bus_io.prism_wdata  = prism_wdata_q;
  assign bus_io.busy         = (state_q != StIdle);
  assign bus_io.done         = (state_q == StRelease) && !bus_io.cmd_abort;
  assign bus_io.error        = error_q;
  assign bus_io.irq          = irq_q;
endmodule

// File: tb/tb_prism_load_seq.sv
// Directed bench for prism_load_seq: latency, address wrap, trickle feed, timeout, abort,
// irq priority and mid-sequence reset.
module tb_prism_load_seq;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prism_load_seq_if bus ();

  prism_load_seq #(
    .FIFO_DEPTH   (4),
    .SETTLE_CYCLES(2),
    .TIMEOUT      (255)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_io(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc;
  int gap;
  int gap_cnt;
  int acc_cnt;
  int done_cyc;
  int err_cyc;
  int n;
  logic [31:0] feed[$];
  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          wr_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: record handshake acceptance, sample #1 after the edge, then redrive inputs.
  task automatic tick();
    logic acc;
    acc = bus.word_valid && bus.word_ready;
    @(posedge clk);
    #1;
    cyc++;
    bus.cmd_start = 1'b0;
    bus.cmd_abort = 1'b0;
    bus.irq_clr   = 1'b0;
    if (acc) begin
      void'(feed.pop_front());
      acc_cnt++;
      gap_cnt = gap;
    end else if (gap_cnt > 0) begin
      gap_cnt--;
    end
    bus.word_valid = (feed.size() > 0) && (gap_cnt == 0);
    bus.word_data  = (feed.size() > 0) ? feed[0] : 32'h0;
    if (bus.prism_wr) begin
      wr_addr.push_back(32'(bus.prism_addr));
      wr_data.push_back(bus.prism_wdata);
      wr_cyc.push_back(cyc);
    end
    if (bus.done) done_cyc = cyc;
    if (bus.error && err_cyc < 0) err_cyc = cyc;
  endtask

  task automatic start(input logic [5:0] base, input logic [3:0] cnt, input logic ar);
    wr_addr.delete();
    wr_data.delete();
    wr_cyc.delete();
    acc_cnt          = 0;
    done_cyc         = -1;
    err_cyc          = -1;
    gap_cnt          = 0;
    cyc              = 0;
    bus.cmd_base     = base;
    bus.cmd_count    = cnt;
    bus.cmd_autorun  = ar;
    bus.cmd_start    = 1'b1;
    bus.word_valid   = (feed.size() > 0);
    bus.word_data    = (feed.size() > 0) ? feed[0] : 32'h0;
    tick();
  endtask

  task automatic wait_done(input int bound);
    n = 0;
    while (!bus.done && n < bound) begin
      tick();
      n++;
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.cmd_start   = 1'b0;
    bus.cmd_base    = '0;
    bus.cmd_count   = '0;
    bus.cmd_autorun = 1'b0;
    bus.cmd_abort   = 1'b0;
    bus.irq_clr     = 1'b0;
    bus.word_valid  = 1'b0;
    bus.word_data   = '0;
    gap             = 0;
    err_cyc         = -1;
    done_cyc        = -1;
    tick();
    tick();
    chk("reset_outputs", {24'h0, bus.prism_reset, bus.prism_enable, bus.irq, bus.error,
                          bus.busy, bus.word_ready, bus.prism_wr, bus.done}, 32'h0);
    rst = 1'b0;
    tick();

    // Latency with prefilled words, autorun.
    feed = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};
    start(6'h08, 4'd3, 1'b1);
    chk("t1_quiesce_reset", {30'h0, bus.prism_reset, bus.busy}, 32'h3);
    chk("t1_quiesce_enable", 32'(bus.prism_enable), 32'h0);
    wait_done(40);
    chk("t1_done_cyc", 32'(done_cyc), 32'd6);
    chk("t1_release_outs", {30'h0, bus.prism_reset, bus.prism_enable}, 32'h1);
    chk("t1_nwr", 32'(wr_cyc.size()), 32'd3);
    if (wr_cyc.size() == 3) begin
      chk("t1_wr_cycles", {8'h0, 8'(wr_cyc[0]), 8'(wr_cyc[1]), 8'(wr_cyc[2])}, 32'h0003_0405);
      chk("t1_wr_addrs", {8'h0, 8'(wr_addr[0]), 8'(wr_addr[1]), 8'(wr_addr[2])}, 32'h0008_0C10);
      chk("t1_wr_data2", wr_data[2], 32'hCCCC_0003);
    end
    tick();
    chk("t1_after_idle", {29'h0, bus.busy, bus.prism_enable, bus.irq}, 32'h3);
    bus.irq_clr = 1'b1;
    tick();
    chk("irq_clear", 32'(bus.irq), 32'h0);

    // Address wrap, autorun off, irq_clr coincident with done.
    feed = '{32'hD0D0_0004, 32'hE0E0_0005, 32'hF0F0_0006};
    start(6'h38, 4'd3, 1'b0);
    chk("t2_enable_cleared", 32'(bus.prism_enable), 32'h0);
    wait_done(40);
    chk("t2_done_cyc", 32'(done_cyc), 32'd6);
    chk("t2_nwr", 32'(wr_addr.size()), 32'd3);
    if (wr_addr.size() == 3) begin
      chk("t2_wr_addrs", {8'h0, 8'(wr_addr[0]), 8'(wr_addr[1]), 8'(wr_addr[2])}, 32'h0038_3C00);
      chk("t2_wr_data0", wr_data[0], 32'hD0D0_0004);
    end
    bus.irq_clr = 1'b1;
    tick();
    chk("t2_irq_set_wins", 32'(bus.irq), 32'h1);
    chk("t2_release_outs", {30'h0, bus.prism_reset, bus.prism_enable}, 32'h0);

    // count=0 means 16 words, trickled one per three cycles; the 17th is refused.
    feed.delete();
    for (int i = 0; i < 17; i++) feed.push_back(32'h1000_0000 + 32'(i));
    gap = 2;
    start(6'h00, 4'd0, 1'b0);
    wait_done(200);
    chk("t3_done_seen", 32'(done_cyc > 0), 32'h1);
    chk("t3_nwr", 32'(wr_addr.size()), 32'd16);
    chk("t3_no_error", 32'(bus.error), 32'h0);
    if (wr_addr.size() == 16) begin
      chk("t3_last_addr", wr_addr[15], 32'h3C);
      chk("t3_last_data", wr_data[15], 32'h1000_000F);
    end
    for (int i = 0; i < 6; i++) tick();
    chk("t3_accepted", 32'(acc_cnt), 32'd16);
    chk("t3_leftover", 32'(feed.size()), 32'd1);
    gap = 0;
    feed.delete();
    tick();

    // One word of two, then silence: timeout after 255 empty LOAD cycles.
    feed = '{32'h6666_0007};
    start(6'h00, 4'd2, 1'b1);
    n = 0;
    while (!bus.error && n < 400) begin
      tick();
      n++;
    end
    chk("t4_err_cyc", 32'(err_cyc), 32'd258);
    chk("t4_err_outs", {28'h0, bus.error, bus.irq, bus.prism_reset, bus.busy}, 32'hE);
    chk("t4_nwr", 32'(wr_addr.size()), 32'd1);
    bus.irq_clr = 1'b1;
    tick();

    // Abort while a write is pending.
    feed = '{32'h4848_0008, 32'h4949_0009};
    start(6'h00, 4'd2, 1'b1);
    chk("t5_error_cleared", 32'(bus.error), 32'h0);
    tick();
    tick();
    chk("t5_first_wr", 32'(bus.prism_wr), 32'h1);
    bus.cmd_abort = 1'b1;
    tick();
    chk("t5_abort_outs", {26'h0, bus.prism_wr, bus.busy, bus.error, bus.irq, bus.prism_reset,
                          bus.prism_enable}, 32'hE);
    chk("t5_nwr", 32'(wr_addr.size()), 32'd1);

    // Abort in IDLE is ignored.
    bus.cmd_abort = 1'b1;
    tick();
    chk("t5_idle_abort", 32'(bus.busy), 32'h0);

    // Flushed FIFO: the next load must see only the new word.
    feed = '{32'h5A5A_000A};
    start(6'h10, 4'd1, 1'b0);
    wait_done(40);
    chk("t6_nwr", 32'(wr_data.size()), 32'd1);
    if (wr_data.size() == 1) chk("t6_data", wr_data[0], 32'h5A5A_000A);
    chk("t6_addr_error", {wr_addr.size() == 1 ? wr_addr[0][7:0] : 8'hFF, 23'h0, bus.error},
        32'h1000_0000);
    tick();

    // Reset mid-sequence.
    feed = '{32'h7777_000B, 32'h8888_000C};
    start(6'h00, 4'd2, 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t7_mid_reset", {24'h0, bus.prism_reset, bus.prism_enable, bus.irq, bus.error,
                         bus.busy, bus.word_ready, bus.prism_wr, bus.done}, 32'h0);
    rst = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
